// File: rtl/minterm_pla_pkg.sv
// minterm_pla_pkg: shared FSM state type and default sizing for the minterm PLA.
package minterm_pla_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_M = 3;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
endpackage

// File: rtl/minterm_pla_onehot_decoder.sv
// onehot_decoder: combinational N-to-2^N one-hot decode, all-zero when disabled.
module onehot_decoder
  import minterm_pla_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] d
);
  assign d = en ? (2**N)'(1) << sel : '0;
endmodule

// File: rtl/minterm_pla.sv
// minterm_pla: per-channel minterm-mask PLA with single evaluations and a full truth-table sweep.
module minterm_pla
  import minterm_pla_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  localparam int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_val,
  input  logic [N-1:0]    in_sel,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [2**N-1:0] cfg_mask,
  input  logic            sweep_start,
  output logic            out_val,
  output logic [N-1:0]    out_idx,
  output logic [M-1:0]    f,
  output logic            busy,
  output logic            done
);
  state_t          r_state, w_next;
  logic [N-1:0]    r_cnt;
  logic [2**N-1:0] r_mask [M];
  logic            r_val;
  logic [N-1:0]    r_idx;
  logic [M-1:0]    r_f;
  logic            w_idle, w_sweep, w_eval, w_en;
  logic [N-1:0]    w_sel;
  logic [2**N-1:0] w_d;
  logic [M-1:0]    w_f;
  assign w_idle  = r_state == IDLE;
  assign w_sweep = r_state == SWEEP;
  assign w_sel   = w_sweep ? r_cnt : in_sel;
  assign w_en    = w_sweep | en;
  assign w_eval  = w_sweep | (w_idle & in_val);
  onehot_decoder #(.N(N)) u_dec (.sel(w_sel), .en(w_en), .d(w_d));
  always_comb begin
    w_f = '0;
    for (int k = 0; k < M; k++) w_f[k] = |(w_d & r_mask[k]);
  end
  always_comb begin
    w_next = r_state;
    if (w_idle && sweep_start) w_next = SWEEP;
    else if (w_sweep && r_cnt == '1) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_idx   <= '0;
      r_f     <= '0;
      for (int k = 0; k < M; k++) r_mask[k] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_idle && sweep_start) ? '0 : w_sweep ? r_cnt + 1'b1 : r_cnt;
      r_val   <= w_eval;
      if (w_eval) begin
        r_idx <= w_sel;
        r_f   <= w_f;
      end
      // channels at or beyond M never match, so out-of-range writes fall away
      for (int k = 0; k < M; k++)
        if (w_idle && cfg_we && cfg_ch == CW'(k)) r_mask[k] <= cfg_mask;
    end
  end
  assign out_val = r_val;
  assign out_idx = r_idx;
  assign f       = r_f;
  assign busy    = !w_idle;
  assign done    = r_state == DONE;
endmodule

// File: tb/tb_minterm_pla.sv
// tb_minterm_pla: directed scoreboard bench for minterm_pla.
module tb_minterm_pla;
  import minterm_pla_pkg::*;
  localparam int N  = DEF_N;
  localparam int M  = DEF_M;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int W  = 1 << N;
  typedef struct packed {
    logic [N-1:0] idx;
    logic [M-1:0] f;
    logic         done;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, in_val = 1'b0, cfg_we = 1'b0, sweep_start = 1'b0;
  logic [N-1:0]  in_sel = '0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_mask = '0;
  logic          out_val, busy, done;
  logic [N-1:0]  out_idx;
  logic [M-1:0]  f;
  exp_t          q[$];
  exp_t          e;
  logic [W-1:0]  m [M];
  int            n_chk = 0, n_fail = 0;
  minterm_pla dut (
    .clk(clk), .rst(rst), .en(en), .in_val(in_val), .in_sel(in_sel),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask), .sweep_start(sweep_start),
    .out_val(out_val), .out_idx(out_idx), .f(f), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [M-1:0] model(logic [N-1:0] s, logic e_en);
    logic [M-1:0] r;
    for (int k = 0; k < M; k++) r[k] = e_en & m[k][s];
    return r;
  endfunction
  always @(negedge clk) begin
    if (out_val) begin
      chk("spurious_out_val", q.size(), 1'b1 ? (q.size() == 0 ? 1 : q.size()) : 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_idx", out_idx, e.idx);
        chk("f", f, e.f);
        chk("done", done, e.done);
      end
    end else chk("done_without_val", done, 0);
  end
  task automatic cfg(int ch, logic [W-1:0] mask);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_mask = mask;
    @(negedge clk);
    cfg_we = 1'b0;
    if (ch < M) m[ch] = mask;
  endtask
  task automatic eval(logic [N-1:0] s, logic e_en);
    q.push_back('{idx: s, f: model(s, e_en), done: 1'b0});
    in_val = 1'b1; in_sel = s; en = e_en;
    @(negedge clk);
    in_val = 1'b0;
  endtask
  task automatic wait_idx(int v);
    int k = 0;
    while (!(out_val && out_idx == N'(v)) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idx_timeout", k < 40, 1);
  endtask
  initial begin
    for (int k = 0; k < M; k++) m[k] = '0;
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_f", f, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    eval(4'd3, 1'b1);
    cfg(0, 16'h4CC8);
    cfg(1, 16'h440C);
    cfg(2, 16'hC08B);
    cfg(3, 16'hFFFF);
    eval(4'd3, 1'b1);
    eval(4'd14, 1'b0);
    eval(4'd14, 1'b1);
    eval(4'd0, 1'b1);
    eval(4'd15, 1'b1);
    q.push_back('{idx: 4'd6, f: model(4'd6, 1'b1), done: 1'b0});
    in_val = 1'b1; in_sel = 4'd6; en = 1'b1;
    cfg(0, 16'h0000);
    in_val = 1'b0;
    eval(4'd6, 1'b1);
    cfg(0, 16'h4CC8);
    @(negedge clk);
    for (int i = 0; i < W; i++) q.push_back('{idx: N'(i), f: model(N'(i), 1'b1), done: i == W - 1});
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    begin
      int n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("busy_cycles", n, 17);
    end
    @(negedge clk);
    chk("queue_drained_sweep", q.size(), 0);
    for (int i = 0; i <= 8; i++) q.push_back('{idx: N'(i), f: model(N'(i), 1'b1), done: 1'b0});
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    wait_idx(5);
    in_val = 1'b1; in_sel = 4'd0; cfg_we = 1'b1; cfg_ch = '0; cfg_mask = '0; sweep_start = 1'b1;
    @(negedge clk);
    in_val = 1'b0; cfg_we = 1'b0; sweep_start = 1'b0;
    wait_idx(8);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_val", out_val, 0);
    chk("midrst_out_idx", out_idx, 0);
    chk("midrst_f", f, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("queue_drained_midsweep", q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < M; k++) m[k] = '0;
    for (int i = 0; i < W; i++) q.push_back('{idx: N'(i), f: '0, done: i == W - 1});
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("restart_busy", busy, 1);
    wait_idx(15);
    @(negedge clk);
    @(negedge clk);
    chk("restart_idle", busy, 0);
    chk("queue_drained_end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
